// File: rtl/fpga_template_pkg.sv
// Shared types for the FPGA template: duty ramp sequencer state, config fields
// and the status word read back over I2C.
package fpga_template_pkg;

  localparam int unsigned RAMP_DUTY_W = 8;
  localparam int unsigned RAMP_DIV_W  = 16;
  localparam int unsigned RAMP_STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD
  } ramp_state_t;

  typedef struct packed {
    logic                   ramp_en;
    logic [RAMP_STEP_W-1:0] ramp_step;
    logic [RAMP_DIV_W-1:0]  ramp_div;
    logic [RAMP_DUTY_W-1:0] duty;
  } sys_cfg_t;

  typedef struct packed {
    logic busy;
    logic at_target;
  } ramp_status_t;

endpackage

// File: rtl/pwm_ramp_tick.sv
// Ramp prescaler: one tick every rate_div+1 cycles while run is high.
module pwm_ramp_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             run,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a lowered rate_div still produces a tick promptly
  assign tick = run && (cnt_q >= rate_div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / soft-stop sequencer: slews duty_out toward the effective target
// in step-sized increments, one increment per prescaler tick.
module pwm_ramp_ctrl
  import fpga_template_pkg::*;
#(
  parameter int unsigned DUTY_W = RAMP_DUTY_W,
  parameter int unsigned DIV_W  = RAMP_DIV_W,
  parameter int unsigned STEP_W = RAMP_STEP_W
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [STEP_W-1:0] step,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              at_target,
  output logic              done_pulse
);

  ramp_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DUTY_W-1:0] eff, step_eff, up_inc, dn_inc, up_val, dn_val;
  logic              run, tick;

  assign eff      = enable ? target_duty : '0;
  assign step_eff = (step == '0) ? DUTY_W'(1) : DUTY_W'(step);
  assign up_inc   = (step_eff < (eff - duty_q)) ? step_eff : (eff - duty_q);
  assign dn_inc   = (step_eff < (duty_q - eff)) ? step_eff : (duty_q - eff);
  assign up_val   = duty_q + up_inc;
  assign dn_val   = duty_q - dn_inc;

  // Prescaler only runs while moving in the current direction; dropping run on
  // a reversal or an arrival clears the count for the next ramp segment.
  assign run = ((state_q == RAMP_UP)   && (eff > duty_q)) ||
               ((state_q == RAMP_DOWN) && (eff < duty_q));

  pwm_ramp_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk     (clk),
    .resetb  (resetb),
    .run     (run),
    .rate_div(rate_div),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eff != '0) state_d = RAMP_UP;
      end
      HOLD: begin
        if (eff > duty_q)      state_d = RAMP_UP;
        else if (eff < duty_q) state_d = RAMP_DOWN;
      end
      RAMP_UP: begin
        if (eff < duty_q) begin
          state_d = RAMP_DOWN;
        end else if (eff == duty_q) begin
          state_d = (duty_q == '0) ? IDLE : HOLD;
          done_d  = 1'b1;
        end else if (tick) begin
          duty_d = up_val;
          if (up_val == eff) begin
            state_d = HOLD;
            done_d  = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        if (eff > duty_q) begin
          state_d = RAMP_UP;
        end else if (eff == duty_q) begin
          state_d = (duty_q == '0) ? IDLE : HOLD;
          done_d  = 1'b1;
        end else if (tick) begin
          duty_d = dn_val;
          if (dn_val == eff) begin
            state_d = (eff == '0) ? IDLE : HOLD;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      duty_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign duty_out   = duty_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign at_target  = (duty_q == eff);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramp scenarios, a per-cycle reference model
// compare, and literal checkpoints at hand-computed cycles.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  target_duty = '0;
  logic [3:0]  step = '0;
  logic [15:0] rate_div = '0;
  logic [7:0]  duty_out;
  logic        busy, at_target, done_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .DUTY_W(8),
    .DIV_W (16),
    .STEP_W(4)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .enable     (enable),
    .target_duty(target_duty),
    .step       (step),
    .rate_div   (rate_div),
    .duty_out   (duty_out),
    .busy       (busy),
    .at_target  (at_target),
    .done_pulse (done_pulse)
  );

  function automatic int eff_now();
    return enable ? int'(target_duty) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: ramping flag, direction sign and elapsed cycles since the
  // current segment began; a step is taken once elapsed reaches rate_div.
  int m_duty = 0;
  bit m_ramp = 1'b0;
  int m_dir  = 0;
  int m_e    = 0;
  bit m_done = 1'b0;

  always @(posedge clk or negedge resetb) begin : model
    int d, se, mag;
    if (!resetb) begin
      m_duty = 0; m_ramp = 1'b0; m_dir = 0; m_e = 0; m_done = 1'b0;
    end else begin
      d  = eff_now() - m_duty;
      se = (step == 0) ? 1 : int'(step);
      m_done = 1'b0;
      if (!m_ramp) begin
        if (d != 0) begin
          m_ramp = 1'b1; m_dir = (d > 0) ? 1 : -1; m_e = 0;
        end
      end else if (d == 0) begin
        m_ramp = 1'b0; m_done = 1'b1;
      end else if (((d > 0) ? 1 : -1) != m_dir) begin
        m_dir = -m_dir; m_e = 0;
      end else if (m_e >= int'(rate_div)) begin
        mag = (d > 0) ? d : -d;
        if (se < mag) mag = se;
        m_duty = m_duty + m_dir * mag;
        m_e = 0;
        if (m_duty == eff_now()) begin
          m_ramp = 1'b0; m_done = 1'b1;
        end
      end else begin
        m_e++;
      end
    end
  end

  always @(negedge clk) begin
    chk("duty_out",   int'(duty_out),   m_duty);
    chk("busy",       int'(busy),       int'(m_ramp));
    chk("done_pulse", int'(done_pulse), int'(m_done));
    chk("at_target",  int'(at_target),  int'(m_duty == eff_now()));
  end

  initial begin
    #1;
    resetb = 1'b0; enable = 1'b1; step = 4'd10; rate_div = 16'd3; target_duty = 8'd0;
    tick_n(2);
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_pulse), 0);
    chk("rst_at_target", int'(at_target), 1);
    resetb = 1'b1;
    tick_n(1);

    // Soft start 0 -> 100, step 10, tick every 4 cycles
    target_duty = 8'd100;
    tick_n(4);
    chk("t1_latency_duty", int'(duty_out), 0);
    chk("t1_busy", int'(busy), 1);
    tick_n(1);
    chk("t1_first_step", int'(duty_out), 10);
    tick_n(4);
    chk("t1_second_step", int'(duty_out), 20);
    tick_n(32);
    chk("t1_final", int'(duty_out), 100);
    chk("t1_done", int'(done_pulse), 1);
    chk("t1_busy_low", int'(busy), 0);
    tick_n(1);
    chk("t1_done_one_cycle", int'(done_pulse), 0);
    chk("t1_at_target", int'(at_target), 1);

    // Small decrease: single clamped step to 95
    target_duty = 8'd95;
    tick_n(1);
    chk("t2_busy", int'(busy), 1);
    chk("t2_hold_duty", int'(duty_out), 100);
    tick_n(4);
    chk("t2_final", int'(duty_out), 95);
    chk("t2_done", int'(done_pulse), 1);
    tick_n(1);
    chk("t2_done_clear", int'(done_pulse), 0);

    // Full scale without wrap, then soft stop
    step = 4'd15; rate_div = 16'd0; target_duty = 8'd255;
    tick_n(11);
    chk("t4_pre_top", int'(duty_out), 245);
    tick_n(1);
    chk("t4_top", int'(duty_out), 255);
    chk("t4_top_done", int'(done_pulse), 1);
    enable = 1'b0;
    tick_n(18);
    chk("t4_stop_duty", int'(duty_out), 0);
    chk("t4_stop_done", int'(done_pulse), 1);
    chk("t4_stop_busy", int'(busy), 0);
    chk("t4_stop_at_target", int'(at_target), 1);

    // Reversal mid-ramp: up toward 200, retarget to 20 at duty 60
    step = 4'd4; target_duty = 8'd200; enable = 1'b1;
    tick_n(16);
    chk("t3_at60", int'(duty_out), 60);
    target_duty = 8'd20;
    tick_n(1);
    chk("t3_reverse_duty", int'(duty_out), 60);
    chk("t3_reverse_nodone", int'(done_pulse), 0);
    chk("t3_reverse_busy", int'(busy), 1);
    tick_n(1);
    chk("t3_first_down", int'(duty_out), 56);
    tick_n(9);
    chk("t3_final", int'(duty_out), 20);
    chk("t3_done", int'(done_pulse), 1);

    // Lowering rate_div mid-count, step 0 acts as 1
    step = 4'd0; rate_div = 16'd1000; target_duty = 8'd30;
    tick_n(501);
    chk("t5_slow_wait", int'(duty_out), 20);
    rate_div = 16'd10;
    tick_n(1);
    chk("t5_immediate_tick", int'(duty_out), 21);
    tick_n(10);
    chk("t5_between", int'(duty_out), 21);
    tick_n(1);
    chk("t5_next_tick", int'(duty_out), 22);
    tick_n(95);
    chk("t5_final", int'(duty_out), 30);

    // Asynchronous reset mid-ramp at 77
    step = 4'd1; rate_div = 16'd0; target_duty = 8'd100;
    tick_n(48);
    chk("t6_at77", int'(duty_out), 77);
    #2;
    resetb = 1'b0;
    #1;
    chk("t6_async_duty", int'(duty_out), 0);
    chk("t6_async_busy", int'(busy), 0);
    tick_n(2);
    resetb = 1'b1;
    tick_n(1);
    chk("t6_restart_busy", int'(busy), 1);
    chk("t6_restart_duty", int'(duty_out), 0);
    tick_n(1);
    chk("t6_restart_first", int'(duty_out), 1);
    tick_n(100);
    chk("t6_final", int'(duty_out), 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
